// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM states and Montgomery multiplier sizing for the RSA modexp engine
package rsa_pkg;
  typedef enum logic [2:0] {IDLE, PRE_M, PRE_X, SQR, MUL, POST, DONE} state_t;
  function automatic int mul_lat(input int w);
    return w + 1;
  endfunction
  function automatic int acc_w(input int w);
    return w + 2;
  endfunction
endpackage

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: bit-serial Montgomery product r = a*b*2^-WIDTH mod p (in: start,a,b,p; out: done pulse, r)
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] r
);
  localparam int AW = acc_w(WIDTH);
  localparam int CW = $clog2(mul_lat(WIDTH) + 1);
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [AW-1:0] u_q, s, t;
  logic [CW-1:0] cnt_q;
  always_comb begin
    s = u_q + (a_q[0] ? AW'(b_q) : '0);
    t = s + (s[0] ? AW'(p_q) : '0);
    done = cnt_q == CW'(1);
    r = WIDTH'(u_q >= AW'(p_q) ? u_q - AW'(p_q) : u_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      u_q <= '0;
      cnt_q <= '0;
    end else if (en) begin
      if (start) begin
        a_q <= a;
        b_q <= b;
        p_q <= p;
        u_q <= '0;
        cnt_q <= CW'(mul_lat(WIDTH));
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q > CW'(1)) begin
          u_q <= t >> 1;
          a_q <= a_q >> 1;
        end
      end
    end
  end
endmodule

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: C = M^E mod P by Montgomery square-and-multiply (in: start,en,P,E,M,Const=R^2 mod P; out: busy,eoc,err,C)
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             eoc,
  output logic             err,
  output logic [WIDTH-1:0] C
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d, mb_q, mb_d, x_q, x_d, c_d;
  logic [WIDTH-1:0] mul_a, mul_b, mul_r;
  logic [IW-1:0] i_q, i_d;
  logic bad_q, bad_d, first_q, first_d, busy_d, eoc_d, err_d, mul_done;
  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .en(en), .start(first_q),
    .a(mul_a), .b(mul_b), .p(p_q), .done(mul_done), .r(mul_r)
  );
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    e_d = e_q;
    m_d = m_q;
    k_d = k_q;
    mb_d = mb_q;
    x_d = x_q;
    i_d = i_q;
    bad_d = bad_q;
    first_d = 1'b0;
    mul_a = state_q == PRE_M ? m_q : state_q == PRE_X ? WIDTH'(1) : state_q == MUL ? mb_q : x_q;
    mul_b = state_q inside {PRE_M, PRE_X} ? k_q : state_q == POST ? WIDTH'(1) : x_q;
    if (state_q inside {IDLE, DONE} && start) begin
      p_d = P;
      e_d = E;
      m_d = M;
      k_d = Const;
      i_d = IW'(WIDTH - 1);
      bad_d = !P[0] || P < WIDTH'(3) || M >= P || Const >= P;
      state_d = bad_d ? DONE : PRE_M;
      first_d = !bad_d;
    end else if (mul_done) begin
      case (state_q)
        PRE_M: begin
          mb_d = mul_r;
          state_d = PRE_X;
        end
        PRE_X: begin
          x_d = mul_r;
          state_d = SQR;
        end
        SQR: begin
          x_d = mul_r;
          state_d = e_q[i_q] ? MUL : i_q != '0 ? SQR : POST;
          i_d = !e_q[i_q] && i_q != '0 ? i_q - IW'(1) : i_q;
        end
        MUL: begin
          x_d = mul_r;
          state_d = i_q != '0 ? SQR : POST;
          i_d = i_q != '0 ? i_q - IW'(1) : i_q;
        end
        POST: begin
          x_d = mul_r;
          state_d = DONE;
        end
        default: state_d = state_q;
      endcase
      first_d = state_q != POST;
    end
    busy_d = !(state_q inside {IDLE, DONE});
    eoc_d = state_q == DONE;
    err_d = eoc_d && bad_q;
    c_d = eoc_d && !bad_q ? x_q : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q <= '0;
      e_q <= '0;
      m_q <= '0;
      k_q <= '0;
      mb_q <= '0;
      x_q <= '0;
      i_q <= '0;
      bad_q <= 1'b0;
      first_q <= 1'b0;
      busy <= 1'b0;
      eoc <= 1'b0;
      err <= 1'b0;
      C <= '0;
    end else if (en) begin
      state_q <= state_d;
      p_q <= p_d;
      e_q <= e_d;
      m_q <= m_d;
      k_q <= k_d;
      mb_q <= mb_d;
      x_q <= x_d;
      i_q <= i_d;
      bad_q <= bad_d;
      first_q <= first_d;
      busy <= busy_d;
      eoc <= eoc_d;
      err <= err_d;
      C <= c_d;
    end
  end
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb_rsa_modexp_engine: directed vectors with hand-computed results for rsa_modexp_engine
module tb_rsa_modexp_engine;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0;
  logic [7:0] P = '0, E = '0, M = '0, Const = '0;
  logic busy, eoc, err;
  logic [7:0] C;
  int n_vec = 0, n_err = 0;
  int lat;
  rsa_modexp_engine #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .P(P), .E(E), .M(M), .Const(Const),
    .busy(busy), .eoc(eoc), .err(err), .C(C)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic [7:0] p, e, m, k, input int mode, output int l);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    P = p;
    E = e;
    M = m;
    Const = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    l = -1;
    busy_ok = 1'b1;
    while (l < 0 && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
      if (eoc) begin
        l = cyc;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) busy_ok = 1'b0;
      start = mode == 1 && (cyc == 40 || cyc == 80);
      if (start) begin
        P = 8'd12;
        M = 8'd200;
      end
      if (mode == 2) en = !(cyc >= 50 && cyc < 70);
      if (mode == 3 && cyc == 50) begin
        rst = 1'b1;
        #1 chk("rst_async_clear", {busy, eoc, err, C}, 0);
        rst = 1'b0;
        l = 0;
      end
    end
    chk("busy_window", busy_ok, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {busy, eoc, err, C}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    go(8'd13, 8'd3, 8'd4, 8'd3, 0, lat);
    chk("t1_latency", lat, 131);
    chk("t1_c", C, 12);
    chk("t1_err", err, 0);
    repeat (5) @(posedge clk);
    #1 chk("t1_c_held", {eoc, C}, {1'b1, 8'd12});
    go(8'd13, 8'hFF, 8'd2, 8'd3, 0, lat);
    chk("t2_latency", lat, 191);
    chk("t2_c", C, 8);
    go(8'd13, 8'h00, 8'd7, 8'd3, 0, lat);
    chk("t2_e0_latency", lat, 111);
    chk("t2_e0_c", C, 1);
    go(8'd13, 8'h05, 8'd0, 8'd3, 0, lat);
    chk("m0_c", C, 0);
    go(8'd12, 8'd3, 8'd4, 8'd3, 0, lat);
    chk("t3_even_latency", lat, 1);
    chk("t3_even_err_c", {err, C}, {1'b1, 8'd0});
    go(8'd13, 8'd3, 8'd13, 8'd3, 0, lat);
    chk("t3_mbig_latency", lat, 1);
    chk("t3_mbig_err_c", {err, C}, {1'b1, 8'd0});
    go(8'd13, 8'd3, 8'd4, 8'd3, 1, lat);
    chk("t4_latency", lat, 131);
    chk("t4_c", C, 12);
    go(8'd13, 8'd3, 8'd4, 8'd3, 0, lat);
    chk("t4_restart_latency", lat, 131);
    chk("t4_restart_c", {err, C}, {1'b0, 8'd12});
    go(8'd13, 8'd3, 8'd4, 8'd3, 2, lat);
    chk("t5_latency", lat, 151);
    chk("t5_c", C, 12);
    go(8'd13, 8'd3, 8'd4, 8'd3, 3, lat);
    go(8'd13, 8'd3, 8'd4, 8'd3, 0, lat);
    chk("t6_latency", lat, 131);
    chk("t6_c", C, 12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
